// File: rtl/mand_solver_hs.sv
// mand_solver_hs: escape-time solver for z <= z^2 + c with valid/ready handshakes, Julia mode and a per-job iteration cap
module mand_solver_hs #(
  parameter int INT_BITS  = 7,
  parameter int FRAC_BITS = 20,
  parameter int ITER_W    = 10,
  parameter int ESC_MAG   = 4,
  localparam int W        = INT_BITS + FRAC_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_re,
  input  logic [W-1:0]        in_im,
  input  logic [W-1:0]        k_re,
  input  logic [W-1:0]        k_im,
  input  logic                julia,
  input  logic [ITER_W-1:0]   max_iter,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   out_count,
  output logic                out_escaped,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // Products carry 2*FRAC_BITS fractional bits, so the radius is scaled to match.
  localparam logic signed [2*W:0] THR = (2*W+1)'(ESC_MAG) <<< (2*FRAC_BITS);
  state_t state_q, state_d;
  logic signed [W-1:0] zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
  logic [ITER_W-1:0] max_q, max_d, iter_q, iter_d, count_q, count_d;
  logic esc_q, esc_d;
  logic signed [2*W-1:0] rr, ii, ri;
  logic signed [2*W:0] mag, dif;
  logic signed [W-1:0] zn_re, zn_im;
  // Full-precision squares, magnitude and the next z (floor-truncated, wrapping).
  always_comb begin
    rr = (2*W)'(zr_q) * (2*W)'(zr_q);
    ii = (2*W)'(zi_q) * (2*W)'(zi_q);
    ri = (2*W)'(zr_q) * (2*W)'(zi_q);
    mag = {rr[2*W-1], rr} + {ii[2*W-1], ii};
    dif = {rr[2*W-1], rr} - {ii[2*W-1], ii};
    zn_re = W'(dif >>> FRAC_BITS) + cr_q;
    zn_im = W'((ri >>> FRAC_BITS) <<< 1) + ci_q;
  end
  // Next-state logic: accept in IDLE, iterate in RUN, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    zr_d = zr_q;
    zi_d = zi_q;
    cr_d = cr_q;
    ci_d = ci_q;
    max_d = max_q;
    iter_d = iter_q;
    count_d = count_q;
    esc_d = esc_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        zr_d = in_re;
        zi_d = in_im;
        cr_d = julia ? k_re : in_re;
        ci_d = julia ? k_im : in_im;
        max_d = max_iter;
        iter_d = '0;
      end
      RUN: if (mag > THR) begin
        state_d = DONE;
        count_d = iter_q;
        esc_d = 1'b1;
      end else if (iter_q == max_q) begin
        state_d = DONE;
        count_d = max_q;
        esc_d = 1'b0;
      end else begin
        zr_d = zn_re;
        zi_d = zn_im;
        iter_d = iter_q + ITER_W'(1);
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // State register with synchronous reset that discards any job in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      zr_q <= '0;
      zi_q <= '0;
      cr_q <= '0;
      ci_q <= '0;
      max_q <= '0;
      iter_q <= '0;
      count_q <= '0;
      esc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zr_q <= zr_d;
      zi_q <= zi_d;
      cr_q <= cr_d;
      ci_q <= ci_d;
      max_q <= max_d;
      iter_q <= iter_d;
      count_q <= count_d;
      esc_q <= esc_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_count = count_q;
  assign out_escaped = esc_q;
endmodule

// File: tb/tb_mand_solver_hs.sv
// tb_mand_solver_hs: scoreboard bench for mand_solver_hs with directed jobs
module tb_mand_solver_hs;
  localparam int W = 27, IW = 10, ONE = 1 << 20;
  logic clock = 0, reset = 1, in_valid = 0, julia = 0, out_ready = 1;
  logic [W-1:0] in_re = 0, in_im = 0, k_re = 0, k_im = 0;
  logic [IW-1:0] max_iter = 0;
  logic in_ready, out_valid, out_escaped, busy;
  logic [IW-1:0] out_count;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [IW-1:0] cnt; logic esc; int due;} exp_t;
  exp_t q[$];
  bit held = 0;

  mand_solver_hs dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .k_re(k_re), .k_im(k_im), .julia(julia),
    .max_iter(max_iter), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_escaped(out_escaped), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare each new result against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset || !out_valid) held = 0;
    else if (!held) begin
      held = 1;
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        chk("count", 64'(out_count), 64'(e.cnt));
        chk("escaped", 64'(out_escaped), 64'(e.esc));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic job(input int re, input int im, input int kre, input int kim, input logic jl,
                     input int mx, input int cnt, input logic esc, input int k, input bit expect_out);
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 500) begin @(negedge clock); n++; end
    if (!in_ready) chk("accept_wait", 64'(in_ready), 1);
    in_re = W'(re); in_im = W'(im); k_re = W'(kre); k_im = W'(kim);
    julia = jl; max_iter = IW'(mx); in_valid = 1;
    @(posedge clock); #1;
    in_valid = 0; in_re = W'($urandom); in_im = W'($urandom);
    k_re = W'($urandom); k_im = W'($urandom); julia = ~jl; max_iter = IW'($urandom);
    if (expect_out) q.push_back('{IW'(cnt), esc, cyc + k + 1});
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 1000) begin @(negedge clock); n++; end
    chk("drain_pending", 64'(q.size()), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_count", 64'(out_count), 0);
    chk("rst_out_escaped", 64'(out_escaped), 0);
    chk("rst_busy", 64'(busy), 0);
    reset = 0;
    job(0, 0, 0, 0, 0, 10, 10, 0, 10, 1);
    job(ONE, ONE, 0, 0, 0, 10, 1, 1, 1, 1);
    job(-2*ONE, 0, 0, 0, 0, 100, 100, 0, 100, 1);
    job(0, 0, 0, ONE, 1, 50, 50, 0, 50, 1);
    job(0, 0, 0, ONE, 0, 50, 50, 0, 50, 1);
    job(ONE/2, 0, 0, 0, 0, 20, 4, 1, 4, 1);
    job(0, 0, ONE, 0, 1, 20, 3, 1, 3, 1);
    job(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    job(2*ONE, ONE, 0, 0, 0, 0, 0, 1, 0, 1);
    job(-ONE, 0, 0, 0, 0, 8, 8, 0, 8, 1);
    drain();
    // Backpressure: result must hold while a second request waits.
    out_ready = 0;
    job(ONE, ONE, 0, 0, 0, 10, 1, 1, 1, 1);
    in_re = W'(ONE); in_im = W'(ONE); julia = 0; max_iter = 10; in_valid = 1;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 100) begin @(negedge clock); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 64'(out_valid), 1);
      chk("bp_out_count", 64'(out_count), 1);
      chk("bp_out_escaped", 64'(out_escaped), 1);
      chk("bp_in_ready", 64'(in_ready), 0);
      @(negedge clock);
    end
    out_ready = 1;
    @(negedge clock);
    chk("handoff_in_ready", 64'(in_ready), 1);
    chk("handoff_out_valid", 64'(out_valid), 0);
    chk("handoff_busy", 64'(busy), 0);
    @(posedge clock); #1;
    in_valid = 0;
    q.push_back('{IW'(1), 1'b1, cyc + 2});
    drain();
    // Reset in the middle of a run discards the job.
    job(0, 0, 0, 0, 0, 10, 10, 0, 10, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("rst_mid_in_ready", 64'(in_ready), 1);
    chk("rst_mid_out_valid", 64'(out_valid), 0);
    chk("rst_mid_busy", 64'(busy), 0);
    job(ONE, ONE, 0, 0, 0, 10, 1, 1, 1, 1);
    drain();
    repeat (20) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
